i2s_sample_tx: RTL

Consumer end of the sample-generator handshake: issues `generate_next` pulses, accepts `sample` on `sample_ready`, and serialises each sample onto a standard I2S link (BCLK, LRCK, SDATA) toward the audio codec. It sits between `sine_reader` and the board-level codec pins. It runs alongside `wave_capture`, which taps the same `sample_ready`/`sample` pair.

---
 rtl/i2s_pkg.sv | 22 ++
 rtl/i2s_sample_tx_if.sv | 13 +
 rtl/i2s_bclk_gen.sv | 49 ++++
 rtl/i2s_sample_tx.sv | 130 +++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S sample transmitter.
package i2s_pkg;

    typedef enum logic [1:0] {
        ST_PRIME      = 2'd0,
        ST_WAIT_FIRST = 2'd1,
        ST_RUN        = 2'd2
    } state_e;

    localparam int I2S_SAMPLE_WIDTH_DEF = 16;

    // Counter width for values 0..v-1; never narrower than one bit.
    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/i2s_sample_tx_if.sv
// Sample-generator handshake: request strobe out, sample plus ready strobe in.
interface i2s_sample_tx_if
    import i2s_pkg::*;
#(
    parameter int SAMPLE_WIDTH = I2S_SAMPLE_WIDTH_DEF
);
    logic                    sample_ready;
    logic [SAMPLE_WIDTH-1:0] sample;
    logic                    generate_next;

    modport master (output sample_ready, output sample, input generate_next);
    modport slave  (input sample_ready, input sample, output generate_next);
endinterface

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: toggles BCLK every BCLK_DIV clk cycles while enabled and
// flags the falling toggle as the bit strobe (combinational, same cycle).
module i2s_bclk_gen
    import i2s_pkg::*;
#(
    parameter int BCLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic bclk,
    output logic strobe
);
    localparam int DIV_W = clog2_f(BCLK_DIV);

    logic [DIV_W-1:0] div_q, div_d;
    logic             bclk_q, bclk_d;
    logic             tc;

    assign tc = (div_q == DIV_W'(BCLK_DIV - 1));

    always_comb begin
        div_d  = div_q;
        bclk_d = bclk_q;
        if (!en) begin
            div_d  = '0;
            bclk_d = 1'b0;
        end else if (tc) begin
            div_d  = '0;
            bclk_d = ~bclk_q;
        end else begin
            div_d  = div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= '0;
            bclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            bclk_q <= bclk_d;
        end
    end

    assign bclk   = bclk_q;
    assign strobe = en && tc && bclk_q;

endmodule

// File: rtl/i2s_sample_tx.sv
// Mono sample to I2S serialiser with upstream request handshake.
// Build option: I2S_TX_UNDERRUN_MUTE_EN loads silence instead of repeating on underrun.
//
// state      | meaning
// PRIME      | one-cycle generate_next to fetch the first sample
// WAIT_FIRST | BCLK idle until the first sample arrives
// RUN        | free-running framing; loads {H,H} each frame
module i2s_sample_tx
    import i2s_pkg::*;
#(
    parameter int SAMPLE_WIDTH = I2S_SAMPLE_WIDTH_DEF,
    parameter int BCLK_DIV     = 4
) (
    input  logic              clk,
    input  logic              reset,
    i2s_sample_tx_if.slave    hs,
    output logic              i2s_bclk,
    output logic              i2s_lrck,
    output logic              i2s_sdata,
    output logic              underrun
);
    localparam int FRAME_W = 2 * SAMPLE_WIDTH;
    localparam int BIT_W   = clog2_f(FRAME_W);
`ifdef I2S_TX_UNDERRUN_MUTE_EN
    localparam bit MUTE_ON_UNDERRUN = 1'b1;
`else
    localparam bit MUTE_ON_UNDERRUN = 1'b0;
`endif

    state_e                  state_q, state_d;
    logic [SAMPLE_WIDTH-1:0] hold_q, hold_d;
    logic                    fresh_q, fresh_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [FRAME_W-1:0]      shift_q, shift_d;
    logic                    gen_q, gen_d;
    logic                    lrck_q, lrck_d;
    logic                    sdata_q, sdata_d;
    logic                    und_q, und_d;
    logic                    run;
    logic                    bclk;
    logic                    strobe;

    assign run = (state_q == ST_RUN);

    i2s_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk_gen (
        .clk    (clk),
        .reset  (reset),
        .en     (run),
        .bclk   (bclk),
        .strobe (strobe)
    );

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        fresh_d = fresh_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        gen_d   = 1'b0;
        lrck_d  = lrck_q;
        sdata_d = sdata_q;
        und_d   = 1'b0;
        case (state_q)
            ST_PRIME: begin
                gen_d   = 1'b1;
                state_d = ST_WAIT_FIRST;
            end
            ST_WAIT_FIRST: begin
                if (hs.sample_ready) begin
                    hold_d  = hs.sample;
                    fresh_d = 1'b1;
                    bit_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (strobe) begin
                    bit_d  = (bit_q == BIT_W'(FRAME_W - 1)) ? '0 : bit_q + BIT_W'(1);
                    lrck_d = (bit_q >= BIT_W'(SAMPLE_WIDTH));
                    if (bit_q == '0) begin
                        shift_d = (MUTE_ON_UNDERRUN && !fresh_q) ? '0 : {hold_q, hold_q};
                        gen_d   = 1'b1;
                        fresh_d = 1'b0;
                        und_d   = !fresh_q;
                    end else begin
                        shift_d = shift_q << 1;
                    end
                    sdata_d = shift_d[FRAME_W-1];
                end
                // A capture coinciding with a load still leaves fresh set.
                if (hs.sample_ready) begin
                    hold_d  = hs.sample;
                    fresh_d = 1'b1;
                end
            end
            default: state_d = ST_PRIME;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_PRIME;
            hold_q  <= '0;
            fresh_q <= 1'b0;
            bit_q   <= '0;
            shift_q <= '0;
            gen_q   <= 1'b0;
            lrck_q  <= 1'b0;
            sdata_q <= 1'b0;
            und_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            fresh_q <= fresh_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            gen_q   <= gen_d;
            lrck_q  <= lrck_d;
            sdata_q <= sdata_d;
            und_q   <= und_d;
        end
    end

    assign hs.generate_next = gen_q;
    assign i2s_bclk         = bclk;
    assign i2s_lrck         = lrck_q;
    assign i2s_sdata        = sdata_q;
    assign underrun         = und_q;

endmodule
